// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core load/store path, the external port and the data memory.
// Handshake: ext_req is held with stable ext_* fields until ext_gnt is seen in the same cycle.
// Read data for an external read arrives as a one-cycle ext_rvalid pulse after that grant.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU-priority sharing with forced external slots after starvation.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmem_arbiter_if.slave       bus,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_ext_cnt,
    output logic                dbg_state
);
    typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
    localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);

    state_t            state, state_next;
    logic [3:0]        starve_cnt, starve_next;
    logic [3:0]        burst_cnt, burst_next;
    logic              owner_ext;
    logic              gnt;
    logic              burst_done;
    logic              rd_capture;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] ext_rdata_q;
    logic              ext_rvalid_q;

    // burst_cnt sits at MAX_BURST only for the yield cycle after an idle-CPU burst,
    // which keeps the external port off the memory for that one cycle.
    assign burst_done = (burst_cnt == BURST_MAX);
    assign owner_ext  = bus.ext_req &
                        ((state == OWN_EXT) | (~bus.cpu_req & ~burst_done));
    assign gnt        = owner_ext;
    assign rd_capture = gnt & ~bus.ext_we;

    always_comb begin
        state_next  = state;
        starve_next = 4'd0;
        burst_next  = 4'd0;
        mem_addr_c  = bus.cpu_addr;
        mem_wdata_c = bus.cpu_wdata;

        bus.mem_read  = bus.cpu_req & ~bus.cpu_we;
        bus.mem_write = bus.cpu_req &  bus.cpu_we;
        if (owner_ext) begin
            bus.mem_read  = bus.ext_req & ~bus.ext_we;
            bus.mem_write = bus.ext_req &  bus.ext_we;
            mem_addr_c    = bus.ext_addr;
            mem_wdata_c   = bus.ext_wdata;
        end

        if (bus.ext_req && !gnt)
            starve_next = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
        if (gnt)
            burst_next = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 4'd1;

        case (state)
            OWN_CPU: begin
                if (bus.ext_req && bus.cpu_req && starve_cnt == STARVE_MAX - 4'd1)
                    state_next = OWN_EXT;
                else if (gnt && !bus.cpu_req && burst_cnt != BURST_MAX - 4'd1)
                    state_next = OWN_EXT;
            end
            OWN_EXT: begin
                // A forced slot is a single grant; an idle-CPU burst ends at MAX_BURST grants.
                if (!bus.ext_req || bus.cpu_req || burst_cnt == BURST_MAX - 4'd1)
                    state_next = OWN_CPU;
            end
            default: state_next = OWN_CPU;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= OWN_CPU;
            starve_cnt   <= 4'd0;
            burst_cnt    <= 4'd0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state        <= state_next;
            starve_cnt   <= starve_next;
            burst_cnt    <= burst_next;
            ext_rvalid_q <= rd_capture;
            if (rd_capture)
                ext_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = owner_ext & bus.cpu_req;
    assign bus.ext_gnt    = gnt;
    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.ext_rvalid = ext_rvalid_q;
    assign dbg_state      = state;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
            perf_ext_cnt   <= 32'd0;
        end else begin
            if (owner_ext && bus.cpu_req)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (gnt)
                perf_ext_cnt <= perf_ext_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_ext_cnt   = 32'd0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural word memory behind the arbiter.
module tb_dmem_arbiter;
    logic        clk;
    logic        reset;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_ext_cnt;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:255];

`ifdef ARB_PERF_CNT_EN
    localparam logic [31:0] EXP_PERF = 32'd4;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .MAX_BURST(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_ext_cnt   (perf_ext_cnt),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural data memory: combinational read, write at the clock edge
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    function automatic logic [31:0] init_word(int idx);
        return 32'hA500_0000 + 32'(idx);
    endfunction

    // driver tasks
    task automatic drive_idle();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.cpu_req = 1; bus.cpu_addr = 32'h4;
        bus.ext_req = 1; bus.ext_addr = 32'h8;
        reset = 1;
        #1;
        total++; if (bus.ext_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0", bus.ext_gnt); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.cpu_stall); end
        total++; if (bus.ext_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.ext_rvalid); end
        total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL rst_state got=%b exp=0", dbg_state); end
        total++; if (perf_ext_cnt !== 32'd0) begin bad++; $display("FAIL rst_perf got=%0d exp=0", perf_ext_cnt); end
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        total++; if (bus.ext_gnt !== 1'b0) begin bad++; $display("FAIL first_gnt got=%b exp=0", bus.ext_gnt); end
        total++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h4)
            begin bad++; $display("FAIL first_cpu rd=%b addr=%h exp rd=1 addr=4", bus.mem_read, bus.mem_addr); end
        total++; if (bus.cpu_rdata !== init_word(1))
            begin bad++; $display("FAIL first_rdata got=%h exp=%h", bus.cpu_rdata, init_word(1)); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_starvation();
        logic exp_g;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h100 + 32'(c * 4);
            bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 32'h80; bus.ext_wdata = 32'(c);
            #1;
            exp_g = ((c % 5) == 4);
            total++; if (bus.ext_gnt !== exp_g) begin bad++; $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, bus.ext_gnt, exp_g); end
            total++; if (bus.cpu_stall !== exp_g) begin bad++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, bus.cpu_stall, exp_g); end
            if (c < 6) begin
                total++; if (bus.mem_write !== exp_g || bus.mem_read !== !exp_g)
                    begin bad++; $display("FAIL starve_mux c=%0d wr=%b rd=%b exp_wr=%b", c, bus.mem_write, bus.mem_read, exp_g); end
            end
            next_cycle();
        end
        drive_idle();
        #1;
        total++; if (perf_stall_cnt !== EXP_PERF) begin bad++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_cnt, EXP_PERF); end
        total++; if (perf_ext_cnt !== EXP_PERF) begin bad++; $display("FAIL perf_ext got=%0d exp=%0d", perf_ext_cnt, EXP_PERF); end
        next_cycle();
    endtask

    task automatic test_burst();
        int   idx = 0;
        logic prev_rd = 0;
        logic exp_g;
        logic [31:0] exp_d;
        drive_idle();
        next_cycle();
        for (int c = 0; c < 14; c++) begin
            bus.cpu_req = 0;
            bus.ext_req = (idx < 10); bus.ext_we = 0; bus.ext_addr = 32'(idx * 4);
            #1;
            exp_g = (c <= 7) || (c == 9) || (c == 10);
            total++; if (bus.ext_gnt !== exp_g) begin bad++; $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, bus.ext_gnt, exp_g); end
            total++; if (bus.ext_rvalid !== prev_rd) begin bad++; $display("FAIL burst_rvalid c=%0d got=%b exp=%b", c, bus.ext_rvalid, prev_rd); end
            if (bus.ext_rvalid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL burst_extra_rvalid c=%0d data=%h exp=none", c, bus.ext_rdata); end
                else begin
                    exp_d = exp_q.pop_front();
                    if (bus.ext_rdata !== exp_d) begin bad++; $display("FAIL burst_rdata c=%0d got=%h exp=%h", c, bus.ext_rdata, exp_d); end
                end
            end
            prev_rd = (bus.ext_gnt === 1'b1);
            if (bus.ext_gnt === 1'b1) begin
                exp_q.push_back(init_word(idx));
                idx++;
            end
            next_cycle();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL burst_pending got=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_ext_write_cpu_load();
        drive_idle();
        bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 32'h40; bus.ext_wdata = 32'hDEADBEEF;
        #1;
        total++; if (bus.ext_gnt !== 1'b1 || bus.mem_write !== 1'b1)
            begin bad++; $display("FAIL wr_gnt gnt=%b wr=%b exp=1/1", bus.ext_gnt, bus.mem_write); end
        next_cycle();
        drive_idle();
        bus.cpu_req = 1; bus.cpu_addr = 32'h40;
        #1;
        total++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_load got=%h exp=deadbeef", bus.cpu_rdata); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL wr_stall got=%b exp=0", bus.cpu_stall); end
        total++; if (bus.ext_rvalid !== 1'b0) begin bad++; $display("FAIL wr_rvalid got=%b exp=0", bus.ext_rvalid); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        drive_idle();
        bus.ext_req = 1; bus.ext_addr = 32'h8;
        #1;
        total++; if (bus.ext_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b exp=1", bus.ext_gnt); end
        next_cycle();
        total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL mid_state_pre got=%b exp=1", dbg_state); end
        total++; if (bus.ext_rvalid !== 1'b1 || bus.ext_rdata !== init_word(2))
            begin bad++; $display("FAIL mid_rvalid_pre v=%b d=%h exp 1/%h", bus.ext_rvalid, bus.ext_rdata, init_word(2)); end
        reset = 1;
        #1;
        total++; if (bus.ext_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid got=%b exp=0", bus.ext_rvalid); end
        total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL mid_state got=%b exp=0", dbg_state); end
        total++; if (bus.ext_rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata got=%h exp=0", bus.ext_rdata); end
        drive_idle();
        next_cycle();
        reset = 0;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = init_word(k);
        reset = 0;
        drive_idle();
        #2;
        test_reset();
        test_starvation();
        test_burst();
        test_ext_write_cpu_load();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
